core_timers: RTL and testbench

CORE_TIMERS -- requirements
Module: core_timers

---
 rtl/core_timers.sv | 142 ++++++++++++++
 tb/tb_core_timers.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/core_timers.sv
// core_timers: free-running cycle and millisecond counters with a 64-bit
// compare interrupt, exposed to the CPU through a 32-byte register window.
module core_timers #(
   parameter int unsigned CLK_HZ    = 50000000,
   parameter logic [31:0] BASE_ADDR = 32'hFF20_0500
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        DReadEnable,
   input  logic        DWriteEnable,
   input  logic [3:0]  DByteEnable,
   input  logic [31:0] DAddress,
   input  logic [31:0] DWriteData,
   output logic [31:0] DReadData,
   output logic [63:0] core_clock_ticks,
   output logic [63:0] miliseconds,
   output logic        oTimerIRQ
);

   localparam int unsigned P  = CLK_HZ / 1000;
   localparam int unsigned PW = $clog2(P);

   logic          sel, rd, wr;
   logic [2:0]    off;
   logic          unused_addr_lsbs;

   logic [PW-1:0] pcnt_q,    pcnt_d;
   logic [63:0]   ticks_q,   ticks_d;
   logic [63:0]   ms_q,      ms_d;
   logic [31:0]   tsnap_q,   tsnap_d;
   logic [31:0]   msnap_q,   msnap_d;
   logic [31:0]   cmp_lo_q,  cmp_lo_d;
   logic [31:0]   cmp_hi_q,  cmp_hi_d;
   logic          ie_q,      ie_d;
   logic          pend_q,    pend_d;
   logic          frz_q,     frz_d;

   logic          cmp_hit, cmp_wr, pend_w1c;

   assign sel = (DAddress[31:5] == BASE_ADDR[31:5]);
   assign off = DAddress[4:2];
   assign rd  = DReadEnable  & sel;
   assign wr  = DWriteEnable & sel;
   assign unused_addr_lsbs = ^DAddress[1:0];

   assign core_clock_ticks = ticks_q;
   assign miliseconds      = ms_q;
   assign oTimerIRQ        = pend_q & ie_q;

   // Combinational register read mux; zero when not selected for bus OR-merge.
   always_comb begin
      DReadData = '0;
      if (rd) begin
         case (off)
            3'd0:    DReadData = ticks_q[31:0];
            3'd1:    DReadData = tsnap_q;
            3'd2:    DReadData = ms_q[31:0];
            3'd3:    DReadData = msnap_q;
            3'd4:    DReadData = cmp_lo_q;
            3'd5:    DReadData = cmp_hi_q;
            3'd6:    DReadData = {29'd0, frz_q, pend_q, ie_q};
            default: DReadData = '0;
         endcase
      end
   end

   // Next-state logic: counters, snapshots, byte-lane writes and PEND priority.
   always_comb begin
      pcnt_d   = pcnt_q;
      ticks_d  = ticks_q;
      ms_d     = ms_q;
      tsnap_d  = tsnap_q;
      msnap_d  = msnap_q;
      cmp_lo_d = cmp_lo_q;
      cmp_hi_d = cmp_hi_q;
      ie_d     = ie_q;
      frz_d    = frz_q;

      if (!frz_q) begin
         ticks_d = ticks_q + 64'd1;
         if (pcnt_q == PW'(P - 1)) begin
            pcnt_d = '0;
            ms_d   = ms_q + 64'd1;
         end else begin
            pcnt_d = pcnt_q + PW'(1);
         end
      end

      // Snapshots take the pre-increment upper halves.
      if (rd && off == 3'd0) tsnap_d = ticks_q[63:32];
      if (rd && off == 3'd2) msnap_d = ms_q[63:32];

      for (int unsigned i = 0; i < 4; i++) begin
         if (wr && DByteEnable[i]) begin
            if (off == 3'd4) cmp_lo_d[8*i +: 8] = DWriteData[8*i +: 8];
            if (off == 3'd5) cmp_hi_d[8*i +: 8] = DWriteData[8*i +: 8];
         end
      end

      if (wr && off == 3'd6 && DByteEnable[0]) begin
         ie_d  = DWriteData[0];
         frz_d = DWriteData[2];
      end

      // Priority: compare rewrite clears > compare hit sets > W1C clears.
      cmp_hit  = (ms_q >= {cmp_hi_q, cmp_lo_q});
      cmp_wr   = wr && (off == 3'd4 || off == 3'd5);
      pend_w1c = wr && off == 3'd6 && DByteEnable[0] && DWriteData[1];
      if (cmp_wr)        pend_d = 1'b0;
      else if (cmp_hit)  pend_d = 1'b1;
      else if (pend_w1c) pend_d = 1'b0;
      else               pend_d = pend_q;
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         pcnt_q   <= '0;
         ticks_q  <= '0;
         ms_q     <= '0;
         tsnap_q  <= '0;
         msnap_q  <= '0;
         cmp_lo_q <= '1;
         cmp_hi_q <= '1;
         ie_q     <= 1'b0;
         pend_q   <= 1'b0;
         frz_q    <= 1'b0;
      end else begin
         pcnt_q   <= pcnt_d;
         ticks_q  <= ticks_d;
         ms_q     <= ms_d;
         tsnap_q  <= tsnap_d;
         msnap_q  <= msnap_d;
         cmp_lo_q <= cmp_lo_d;
         cmp_hi_q <= cmp_hi_d;
         ie_q     <= ie_d;
         pend_q   <= pend_d;
         frz_q    <= frz_d;
      end
   end

endmodule

// File: tb/tb_core_timers.sv
// Directed bench for core_timers with P=4 (CLK_HZ=4000).
module tb_core_timers;

   localparam logic [31:0] BASE = 32'hFF20_0500;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        DReadEnable, DWriteEnable;
   logic [3:0]  DByteEnable;
   logic [31:0] DAddress, DWriteData;
   logic [31:0] DReadData;
   logic [63:0] core_clock_ticks, miliseconds;
   logic        oTimerIRQ;

   int n_chk  = 0;
   int n_fail = 0;
   int edges  = 0;

   core_timers #(.CLK_HZ(4000), .BASE_ADDR(BASE)) dut (
      .iCLK             (iCLK),
      .iRST             (iRST),
      .DReadEnable      (DReadEnable),
      .DWriteEnable     (DWriteEnable),
      .DByteEnable      (DByteEnable),
      .DAddress         (DAddress),
      .DWriteData       (DWriteData),
      .DReadData        (DReadData),
      .core_clock_ticks (core_clock_ticks),
      .miliseconds      (miliseconds),
      .oTimerIRQ        (oTimerIRQ)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      edges++;
      @(negedge iCLK);
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] be);
      DAddress     = BASE + {27'd0, off, 2'b00};
      DWriteData   = d;
      DByteEnable  = be;
      DWriteEnable = 1'b1;
      tick();
      DWriteEnable = 1'b0;
   endtask

   // Low address bits set to 2'b11 to show they are ignored.
   task automatic chk_rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
      DAddress    = BASE + {27'd0, off, 2'b11};
      DReadEnable = 1'b1;
      #1;
      chk(tag, {32'd0, DReadData}, {32'd0, exp});
      DReadEnable = 1'b0;
   endtask

   initial begin
      int guard;
      bit irq_seen;
      int frz_at;

      iRST = 1'b1; DReadEnable = 1'b0; DWriteEnable = 1'b0;
      DByteEnable = '0; DAddress = '0; DWriteData = '0;

      // Reset state
      @(negedge iCLK);
      chk("rst_ticks", core_clock_ticks, 64'd0);
      chk("rst_ms", miliseconds, 64'd0);
      chk("rst_irq", {63'd0, oTimerIRQ}, 64'd0);
      chk_rd("rst_cmp_lo", 3'd4, 32'hFFFF_FFFF);
      chk_rd("rst_ctrl", 3'd6, 32'd0);
      tick();
      chk("rst_hold_ticks", core_clock_ticks, 64'd0);

      // Prescaler: 12 cycles -> 12 ticks, 3 ms
      iRST = 1'b0; edges = 0;
      repeat (12) tick();
      chk("presc_ticks", core_clock_ticks, 64'd12);
      chk("presc_ms", miliseconds, 64'd3);
      chk_rd("ms_lo", 3'd2, 32'd3);

      // Snapshot across the 32-bit carry
      force dut.ticks_q = 64'h0000_0001_FFFF_FFFF;
      #1 release dut.ticks_q;
      DAddress = BASE; DReadEnable = 1'b1;
      #1;
      chk("snap_lo", {32'd0, DReadData}, 64'hFFFF_FFFF);
      tick();
      DAddress = BASE + 32'd4;
      #1;
      chk("snap_hi", {32'd0, DReadData}, 64'h1);
      DReadEnable = 1'b0;
      chk("snap_live", core_clock_ticks, 64'h0000_0002_0000_0000);

      // Interrupt: CMP=2, IE=1
      iRST = 1'b1;
      tick();
      iRST = 1'b0; edges = 0;
      wr(3'd4, 32'd2, 4'hF);
      wr(3'd5, 32'd0, 4'hF);
      wr(3'd6, 32'd1, 4'hF);
      repeat (5) tick();
      chk("irq_ms2", miliseconds, 64'd2);
      chk("irq_not_yet", {63'd0, oTimerIRQ}, 64'd0);
      tick();
      chk("irq_set", {63'd0, oTimerIRQ}, 64'd1);
      chk_rd("ctrl_pend", 3'd6, 32'd3);
      wr(3'd6, 32'd3, 4'h1);
      chk("w1c_set_wins", {63'd0, oTimerIRQ}, 64'd1);

      // Compare rewrite clears PEND until ms reaches 0x100
      wr(3'd4, 32'h100, 4'hF);
      chk("rewrite_irq", {63'd0, oTimerIRQ}, 64'd0);
      chk_rd("rewrite_ctrl", 3'd6, 32'd1);
      guard = 0; irq_seen = 1'b0;
      while (miliseconds != 64'h100 && guard < 2000) begin
         if (oTimerIRQ) irq_seen = 1'b1;
         tick();
         guard++;
      end
      chk("ms_reach_0x100", {63'd0, guard < 2000}, 64'd1);
      chk("irq_quiet", {63'd0, irq_seen}, 64'd0);
      chk("irq_at_0x100", {63'd0, oTimerIRQ}, 64'd0);
      chk("ticks_at_0x100", core_clock_ticks, 64'(edges));
      tick();
      chk("irq_after_0x100", {63'd0, oTimerIRQ}, 64'd1);

      // Freeze: counters hold for 10 cycles
      wr(3'd6, 32'h4, 4'h1);
      frz_at = edges;
      repeat (10) tick();
      chk("frz_ticks", core_clock_ticks, 64'(frz_at));
      chk("frz_ms", miliseconds, 64'(frz_at / 4));
      chk_rd("frz_ctrl", 3'd6, 32'h6);
      chk("frz_irq_masked", {63'd0, oTimerIRQ}, 64'd0);
      DAddress = 32'h0000_0500; DReadEnable = 1'b1;
      #1;
      chk("unsel_read", {32'd0, DReadData}, 64'd0);
      DReadEnable = 1'b0;
      chk_rd("off7_read", 3'd7, 32'd0);

      // Async reset between edges with PEND=1
      wr(3'd6, 32'h1, 4'h1);
      chk("pre_rst_irq", {63'd0, oTimerIRQ}, 64'd1);
      #1 iRST = 1'b1;
      #1;
      chk("arst_irq", {63'd0, oTimerIRQ}, 64'd0);
      chk("arst_ticks", core_clock_ticks, 64'd0);
      chk("arst_ms", miliseconds, 64'd0);
      chk_rd("arst_cmp_hi", 3'd5, 32'hFFFF_FFFF);
      @(negedge iCLK);
      iRST = 1'b0; edges = 0;
      tick();
      chk("first_inc", core_clock_ticks, 64'd1);
      chk_rd("no_resid_pend", 3'd6, 32'd0);

      // Byte lanes
      wr(3'd4, 32'hAABB_CCDD, 4'b0010);
      chk_rd("lane_cmp_lo", 3'd4, 32'hFFFF_CCFF);

      // Simultaneous read and write returns pre-write value
      DAddress = BASE + 32'd20; DWriteData = 32'h1234; DByteEnable = 4'hF;
      DWriteEnable = 1'b1; DReadEnable = 1'b1;
      #1;
      chk("rw_pre", {32'd0, DReadData}, 64'hFFFF_FFFF);
      tick();
      DWriteEnable = 1'b0; DReadEnable = 1'b0;
      chk_rd("rw_post", 3'd5, 32'h1234);

      // Writes to read-only offsets ignored
      wr(3'd0, 32'd0, 4'hF);
      wr(3'd7, 32'hFFFF_FFFF, 4'hF);
      chk("ro_ticks", core_clock_ticks, 64'(edges));
      chk_rd("ro_off7", 3'd7, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
